// File: rtl/game_control.sv
// Controller FSM for the up/down number-guessing game: it issues a new secret request, counts guesses and reports hints, win and game over.
// Optional feature GAME_AUTO_RESTART_EN: the game restarts on its own RESTART_DELAY cycles after it ends.
module game_control #(
  parameter int unsigned MAX_ATTEMPTS  = 10,
  parameter int unsigned RESTART_DELAY = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] comparison_result,
  output logic       start_random_gen,
  output logic [6:0] game_status,
  output logic       game_over
);

  localparam int unsigned CW = 4;
  localparam logic [1:0] CMP_CORRECT = 2'b00;
  localparam logic [1:0] CMP_UP      = 2'b01;
  localparam logic [1:0] CMP_DOWN    = 2'b10;

  // The wait counter needs at least two cycles: one for WIN/LOSE and one for WAIT.
  if (MAX_ATTEMPTS == 0 || MAX_ATTEMPTS > 15 || RESTART_DELAY < 2) begin : g_param_check
    $error("game_control: parameter out of range");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_PLAY,
    S_WIN,
    S_LOSE
`ifdef GAME_AUTO_RESTART_EN
    , S_WAIT
`endif
  } state_t;

  state_t        state;
  logic [CW-1:0] attempts;
  logic          up_hint;
  logic          down_hint;
  logic          win;
  logic [CW-1:0] attempts_inc;

  assign attempts_inc = attempts + CW'(1);
  assign game_status  = {win, down_hint, up_hint, attempts};

`ifdef GAME_AUTO_RESTART_EN
  localparam int unsigned DW = $clog2(RESTART_DELAY + 1);
  logic [DW-1:0] delay_cnt;
`endif

  // Game sequencing; every output bit is a flop updated here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= S_IDLE;
      attempts         <= '0;
      up_hint          <= 1'b0;
      down_hint        <= 1'b0;
      win              <= 1'b0;
      game_over        <= 1'b0;
      start_random_gen <= 1'b0;
`ifdef GAME_AUTO_RESTART_EN
      delay_cnt        <= '0;
`endif
    end else begin
      start_random_gen <= 1'b0;
      case (state)
        // The pulse is raised on entry so that it is high for the START cycle only.
        S_IDLE: begin
          state            <= S_START;
          start_random_gen <= 1'b1;
          attempts         <= '0;
          up_hint          <= 1'b0;
          down_hint        <= 1'b0;
          win              <= 1'b0;
          game_over        <= 1'b0;
        end
        S_START: begin
          state <= S_PLAY;
        end
        S_PLAY: begin
          case (comparison_result)
            CMP_CORRECT: begin
              win       <= 1'b1;
              game_over <= 1'b1;
              state     <= S_WIN;
            end
            CMP_UP, CMP_DOWN: begin
              attempts  <= attempts_inc;
              up_hint   <= (comparison_result == CMP_UP);
              down_hint <= (comparison_result == CMP_DOWN);
              if (attempts_inc == CW'(MAX_ATTEMPTS)) begin
                game_over <= 1'b1;
                state     <= S_LOSE;
              end
            end
            default: begin
            end
          endcase
        end
`ifdef GAME_AUTO_RESTART_EN
        S_WIN, S_LOSE: begin
          state     <= S_WAIT;
          delay_cnt <= DW'(1);
        end
        // The cycle counted RESTART_DELAY-1 hands over to START.
        S_WAIT: begin
          if (delay_cnt == DW'(RESTART_DELAY - 1)) begin
            state            <= S_START;
            start_random_gen <= 1'b1;
            attempts         <= '0;
            up_hint          <= 1'b0;
            down_hint        <= 1'b0;
            win              <= 1'b0;
            game_over        <= 1'b0;
            delay_cnt        <= '0;
          end else begin
            delay_cnt <= delay_cnt + DW'(1);
          end
        end
`else
        S_WIN, S_LOSE: begin
          state <= state;
        end
`endif
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_control.sv
// Directed, table-driven bench for game_control.
module tb_game_control;

  logic       clk;
  logic       reset;
  logic [1:0] comparison_result;
  logic       start_random_gen;
  logic [6:0] game_status;
  logic       game_over;

  int n_tests;
  int n_fail;

  game_control #(.MAX_ATTEMPTS(10), .RESTART_DELAY(16)) dut (
    .clk               (clk),
    .reset             (reset),
    .comparison_result (comparison_result),
    .start_random_gen  (start_random_gen),
    .game_status       (game_status),
    .game_over         (game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [1:0] cr;
    logic       pulse;
    logic [6:0] status;
    logic       over;
  } vec_t;

  vec_t vecs [15];

  function automatic vec_t mk(input string n, input logic [1:0] cr, input logic p,
                              input logic [6:0] s, input logic o);
    vec_t v;
    v.name   = n;
    v.cr     = cr;
    v.pulse  = p;
    v.status = s;
    v.over   = o;
    return v;
  endfunction

  task automatic check(input string name, input logic p, input logic [6:0] s, input logic o);
    n_tests++;
    if (start_random_gen !== p || game_status !== s || game_over !== o) begin
      n_fail++;
      $display("FAIL %s: got pulse=%b status=%b over=%b, expected pulse=%b status=%b over=%b",
               name, start_random_gen, game_status, game_over, p, s, o);
    end
  endtask

  task automatic step(input logic [1:0] cr);
    comparison_result = cr;
    @(posedge clk);
    #1;
  endtask

  // Reset asserted on a negative edge, released on a later negative edge.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    comparison_result = 2'b11;
    repeat (2) @(negedge clk);
    check("in_reset", 1'b0, 7'd0, 1'b0);
    reset = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;

    vecs[0] = mk("start_pulse", 2'b11, 1'b1, 7'd0, 1'b0);
    vecs[1] = mk("start_ignores_cr", 2'b01, 1'b0, 7'd0, 1'b0);
    for (int i = 1; i <= 10; i++)
      vecs[i+1] = mk($sformatf("lose_cnt%0d", i), 2'b01, 1'b0, {3'b001, 4'(i)}, (i == 10));
    for (int i = 0; i < 3; i++)
      vecs[12+i] = mk($sformatf("lose_hold%0d", i), 2'b01, 1'b0, 7'b0011010, 1'b1);

    reset = 1'b1;
    comparison_result = 2'b11;
    #50;
    check("reset_hold", 1'b0, 7'd0, 1'b0);
    #50;
    reset = 1'b0;

    for (int i = 0; i < 15; i++) begin
      step(vecs[i].cr);
      check(vecs[i].name, vecs[i].pulse, vecs[i].status, vecs[i].over);
    end

    // Win after a DOWN then an UP hint; terminal state holds.
    do_reset();
    step(2'b11); check("win_start", 1'b1, 7'd0, 1'b0);
    step(2'b11); check("win_play",  1'b0, 7'd0, 1'b0);
    step(2'b10); check("win_down",  1'b0, 7'b0100001, 1'b0);
    step(2'b01); check("win_up",    1'b0, 7'b0010010, 1'b0);
    step(2'b00); check("win_hit",   1'b0, 7'b1010010, 1'b1);
    step(2'b01); check("win_hold0", 1'b0, 7'b1010010, 1'b1);
    step(2'b10); check("win_hold1", 1'b0, 7'b1010010, 1'b1);

`ifdef GAME_AUTO_RESTART_EN
    begin
      int edges;
      edges = 2;
      while (game_over === 1'b1 && edges < 40) begin
        step(2'b11);
        edges++;
      end
      n_tests++;
      if (edges != 16) begin
        n_fail++;
        $display("FAIL restart_delay: got %0d edges, expected 16", edges);
      end
      check("restart_state", 1'b1, 7'd0, 1'b0);
      step(2'b11); check("restart_pulse_end", 1'b0, 7'd0, 1'b0);
    end
`endif

    // Idle verdict holds state, then an asynchronous mid-cycle reset.
    do_reset();
    step(2'b11); check("mid_start", 1'b1, 7'd0, 1'b0);
    step(2'b11);
    step(2'b10); check("mid_guess", 1'b0, 7'b0100001, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(2'b11);
      check($sformatf("idle_hold%0d", i), 1'b0, 7'b0100001, 1'b0);
    end
    #3;
    reset = 1'b1;
    #1;
    check("async_reset", 1'b0, 7'd0, 1'b0);
    #2;
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
